// File: rtl/sum_sq.sv
// Sequential a*a + b*b by shift-add, one operand bit per cycle (a first, then b).
// Feeds a downstream sqrt stage through done and y_b.
module sum_sq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_b,
  input  logic [W-1:0] b_b,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [23:0]  y_b
);

  localparam int AW = 2 * W + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_A = 2'd1,
    SQ_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [23:0]     y_q, y_d;

  logic [W-1:0]    operand_s;
  logic [AW-1:0]   addend_s;
  logic [AW-1:0]   sum_s;
  logic            last_s;

  // Datapath: select the operand being squared and form the partial-product sum.
  always_comb begin
    operand_s = {W{1'b0}};
    if (state_q == SQ_B) begin
      operand_s = b_q;
    end else begin
      operand_s = a_q;
    end
    if (operand_s[cnt_q] == 1'b1) begin
      addend_s = AW'(operand_s) << cnt_q;
    end else begin
      addend_s = {AW{1'b0}};
    end
    sum_s  = acc_q + addend_s;
    last_s = (cnt_q == CW'(W - 1));
  end

  // Next-state and output logic; done defaults low so it can only pulse.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start == 1'b1) begin
          a_d     = a_b;
          b_d     = b_b;
          acc_d   = {AW{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = SQ_A;
        end else begin
          busy_d  = 1'b0;
        end
      end
      SQ_A: begin
        acc_d = sum_s;
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = SQ_B;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      SQ_B: begin
        acc_d = sum_s;
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          y_d     = 24'(sum_s);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      acc_q   <= {AW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= 24'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y_b  = y_q;

endmodule

// File: tb/tb_sum_sq.sv
// Self-checking bench for sum_sq (W=8): vector table, corner-case sequences,
// and randomized operands against an arithmetic reference.
module tb_sum_sq;

  logic        clk;
  logic        rst;
  logic [7:0]  a_b;
  logic [7:0]  b_b;
  logic        start;
  logic        busy;
  logic        done;
  logic [23:0] y_b;

  int tests;
  int fails;
  int prev_y;

  sum_sq #(.W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_b   (a_b),
    .b_b   (b_b),
    .start (start),
    .busy  (busy),
    .done  (done),
    .y_b   (y_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         exp_y;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_model(input int a, input int b);
    return a * a + b * b;
  endfunction

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Waits for done; returns the number of rising edges waited (bounded).
  task automatic wait_done(input bit scribble, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (scribble) begin
        a_b = 8'($urandom);
        b_b = 8'($urandom);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_y,
                        input bit scribble, input string name);
    int n;
    @(negedge clk);
    a_b = a;
    b_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy_after_start"}, int'(busy), 1);
    check({name, "_y_held"}, int'(y_b), prev_y);
    wait_done(scribble, n);
    check({name, "_latency"}, n, 16);
    check({name, "_y"}, int'(y_b), exp_y);
    check({name, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, int'(done), 0);
    check({name, "_y_hold_after"}, int'(y_b), exp_y);
    prev_y = exp_y;
  endtask

  initial begin
    int n;
    int cnt;
    logic [7:0] ra;
    logic [7:0] rb;
    tests = 0;
    fails = 0;
    prev_y = 0;
    rst = 1'b1;
    start = 1'b0;
    a_b = 8'd0;
    b_b = 8'd0;

    vecs[0] = '{8'd255, 8'd255, 130050};
    vecs[1] = '{8'd128, 8'd128, 32768};
    vecs[2] = '{8'd3,   8'd4,   25};
    vecs[3] = '{8'd0,   8'd0,   0};
    vecs[4] = '{8'd1,   8'd0,   1};
    vecs[5] = '{8'd0,   8'd200, 40000};

    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_y", int'(y_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_y, 1'b0, $sformatf("vec%0d", i));
    end

    // Chained sqrt stage: root of the 255/255 result.
    run_op(8'd255, 8'd255, 130050, 1'b0, "chain");
    check("chain_sqrt", isqrt(int'(y_b)), 360);

    // Start asserted mid-computation must be ignored.
    @(negedge clk);
    a_b = 8'd255;
    b_b = 8'd255;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_b = 8'd1;
    b_b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, n);
    check("ignore_latency", n, 12);
    check("ignore_y", int'(y_b), 130050);
    cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("ignore_single_done", cnt, 0);
    check("ignore_y_hold", int'(y_b), 130050);

    // Back-to-back: start held high during the done cycle.
    @(negedge clk);
    a_b = 8'd3;
    b_b = 8'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, n);
    check("b2b_first_latency", n, 16);
    check("b2b_first_y", int'(y_b), 25);
    a_b = 8'd5;
    b_b = 8'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_busy", int'(busy), 1);
    wait_done(1'b0, n);
    check("b2b_done_spacing", n + 1, 17);
    check("b2b_second_y", int'(y_b), 169);

    // Reset at edge 8 of a computation aborts it.
    @(posedge clk);
    @(negedge clk);
    a_b = 8'd200;
    b_b = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_y", int'(y_b), 0);
    cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    a_b = 8'd200;
    b_b = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post_rst_accept", int'(busy), 1);
    wait_done(1'b0, n);
    check("post_rst_latency", n, 16);
    check("post_rst_y", int'(y_b), 50000);
    prev_y = 50000;
    @(posedge clk);

    // Random operands, inputs scribbled during computation.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, ref_model(int'(ra), int'(rb)), 1'b1, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
